// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with register 0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_2r1w #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   localparam int DEPTH = 2 ** ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] D,
   input  logic              WE,
   output logic [DATA_W-1:0] Q1,
   output logic [DATA_W-1:0] Q2
);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   assign wr_ok = WE && (WA != '0);

   // Reset is tested first so an unknown WE cannot block the clear.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[WA] <= D;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (RA1 != '0) rd1 = regs[RA1];
      if (RA2 != '0) rd2 = regs[RA2];
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd1;
   logic fwd2;

   assign fwd1 = !RST && wr_ok && (RA1 == WA);
   assign fwd2 = !RST && wr_ok && (RA2 == WA);
   assign Q1   = fwd1 ? D : rd1;
   assign Q2   = fwd2 ? D : rd2;
`else
   assign Q1 = rd1;
   assign Q2 = rd2;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
// Honors REGFILE_BYPASS_EN for the read-during-write expectation.
module tb_reg_file_2r1w;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [4:0]  RA1 = '0;
   logic [4:0]  RA2 = '0;
   logic [4:0]  WA  = '0;
   logic [31:0] D   = '0;
   logic        WE  = 1'b0;
   logic [31:0] Q1;
   logic [31:0] Q2;

   int total = 0;
   int bad   = 0;

   reg_file_2r1w dut (
      .CLK(CLK),
      .RST(RST),
      .RA1(RA1),
      .RA2(RA2),
      .WA (WA),
      .D  (D),
      .WE (WE),
      .Q1 (Q1),
      .Q2 (Q2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WE = 1'b1;
      WA = a;
      D  = d;
      tick();
      WE = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      RA1 = a1;
      RA2 = a2;
      #1;
   endtask

   logic [31:0] exp_v;
   logic [31:0] rdw_exp;

   initial begin
      // power-up reset
      RST = 1'b1;
      tick();
      RST = 1'b0;
      rd(5'd0, 5'd5);
      check("rst_q1_a0", Q1, 32'h0);
      check("rst_q2_a5", Q2, 32'h0);
      rd(5'd31, 5'd1);
      check("rst_q1_a31", Q1, 32'h0);
      check("rst_q2_a1", Q2, 32'h0);

      // reset clears a written register
      wr(5'd5, 32'hDEADBEEF);
      rd(5'd5, 5'd5);
      check("wr5_q1", Q1, 32'hDEADBEEF);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      rd(5'd5, 5'd0);
      check("rst_clr_r5", Q1, 32'h0);

      // write / read both ports
      wr(5'd9, 32'h12345678);
      rd(5'd9, 5'd9);
      check("wr9_q1", Q1, 32'h12345678);
      check("wr9_q2", Q2, 32'h12345678);

      // register zero ignores writes
      wr(5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd0);
      check("zero_q1", Q1, 32'h0);
      check("zero_q2", Q2, 32'h0);

      // reset beats write; no forwarding during reset
      RST = 1'b1;
      WE  = 1'b1;
      WA  = 5'd3;
      D   = 32'hA5A5A5A5;
      rd(5'd9, 5'd3);
      check("rstpri_pre_q2", Q2, 32'h0);
      tick();
      RST = 1'b0;
      WE  = 1'b0;
      rd(5'd9, 5'd3);
      check("rstpri_q2", Q2, 32'h0);
      check("rstpri_r9", Q1, 32'h0);

      // read during write
      wr(5'd7, 32'h11);
      WE = 1'b1;
      WA = 5'd7;
      D  = 32'h22;
      rd(5'd7, 5'd8);
`ifdef REGFILE_BYPASS_EN
      rdw_exp = 32'h22;
`else
      rdw_exp = 32'h11;
`endif
      check("rdw_pre_q1", Q1, rdw_exp);
      check("rdw_other_q2", Q2, 32'h0);
      tick();
      WE = 1'b0;
      rd(5'd7, 5'd7);
      check("rdw_post_q1", Q1, 32'h22);
      check("rdw_post_q2", Q2, 32'h22);

      // sweep all registers
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         exp_v = 32'(i) * 32'h01010101;
         rd(5'(i), 5'(31 - i));
         check($sformatf("sweep_q1_%0d", i), Q1, exp_v);
         check($sformatf("sweep_q2_%0d", 31 - i), Q2,
               32'(31 - i) * 32'h01010101);
      end

      // WE=0 cycles with noisy D change nothing
      for (int k = 0; k < 8; k++) begin
         WE = 1'b0;
         WA = 5'($urandom_range(0, 31));
         D  = $urandom;
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(i));
         exp_v = 32'(i) * 32'h01010101;
         check($sformatf("hold_q1_%0d", i), Q1, exp_v);
         check($sformatf("hold_q2_%0d", i), Q2, exp_v);
      end

      // final reset wipes everything
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 32; i += 4) begin
         rd(5'(i), 5'(i + 3));
         check($sformatf("final_q1_%0d", i), Q1, 32'h0);
         check($sformatf("final_q2_%0d", i + 3), Q2, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
